// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and constants for the data memory arbiter.
package dmem_arb_pkg;

   localparam int ADDR_W_DEF    = 32;
   localparam int DATA_W_DEF    = 32;
   localparam int MEM_DEPTH_DEF = 256;

   localparam int REQ_CORE = 0;
   localparam int REQ_DMA  = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester handshake and memory bus of the data memory arbiter.
// slave = arbiter view, master = requesters plus memory.
interface data_mem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) ();

   logic [1:0]          req;
   logic [1:0]          req_we;
   logic [2*ADDR_W-1:0] req_addr;
   logic [2*DATA_W-1:0] req_wdata;
   logic [1:0]          gnt;
   logic [1:0]          rsp_valid;
   logic [DATA_W-1:0]   rsp_rdata;
   logic                rsp_err;

   logic                mem_MemWrite;
   logic                mem_MemRead;
   logic [ADDR_W-1:0]   mem_Address;
   logic [DATA_W-1:0]   mem_Write_data;
   logic [DATA_W-1:0]   mem_Read_data;

   modport slave (
      input  req, req_we, req_addr, req_wdata, mem_Read_data,
      output gnt, rsp_valid, rsp_rdata, rsp_err,
      output mem_MemWrite, mem_MemRead, mem_Address, mem_Write_data
   );

   modport master (
      output req, req_we, req_addr, req_wdata, mem_Read_data,
      input  gnt, rsp_valid, rsp_rdata, rsp_err,
      input  mem_MemWrite, mem_MemRead, mem_Address, mem_Write_data
   );

endinterface

// File: rtl/data_mem_arbiter_pick.sv
// Two-way winner select: a lone request wins outright, a tie goes to
// the requester named by ptr.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] win
);

   always_comb begin
      win = req;
      if (req == 2'b11) begin
         win = (ptr == 1'(REQ_DMA)) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Core/DMA data memory arbiter: fixed 4-cycle grant/setup/access/response.
// Define DMEM_ARB_RR_EN for round-robin ties; default is fixed core priority.
//
// state     | meaning
// ST_IDLE   | waiting; on any req pulse gnt and latch the winner's payload
// ST_GRANT  | address/data setup from the latch, strobes low
// ST_ACCESS | one memory strobe (none if out of range), read data sampled
// ST_RESP   | rsp_valid to the latched requester with rdata/err
module data_mem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   data_mem_arbiter_if.slave  bus,
   output logic               busy
);

   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(MEM_DEPTH);

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              oor_q, oor_d;
   logic [1:0]        win_oh;
   logic [1:0]        gnt_oh;
   logic              ptr;

   dmem_arb_pick u_pick (
      .req (bus.req),
      .ptr (ptr),
      .win (win_oh)
   );

`ifdef DMEM_ARB_RR_EN
   logic ptr_q, ptr_d;

   // Tie preference flips to the other requester after every grant.
   always_comb begin
      ptr_d = ptr_q;
      if (state_q == ST_IDLE && bus.req != 2'b00) begin
         ptr_d = win_oh[REQ_CORE];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'(REQ_CORE);
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = 1'(REQ_CORE);
`endif

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      oor_d   = oor_q;
      gnt_oh  = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (bus.req != 2'b00) begin
               gnt_oh  = win_oh;
               sel_d   = win_oh;
               we_d    = win_oh[REQ_DMA] ? bus.req_we[REQ_DMA] : bus.req_we[REQ_CORE];
               addr_d  = win_oh[REQ_DMA] ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                         : bus.req_addr[ADDR_W-1:0];
               wdata_d = win_oh[REQ_DMA] ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                         : bus.req_wdata[DATA_W-1:0];
               oor_d   = ({1'b0, addr_d} >= DEPTH_X);
               rdata_d = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            rdata_d = (!we_q && !oor_q) ? bus.mem_Read_data : '0;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         oor_q   <= oor_d;
      end
   end

   // gnt is combinational off req, so it is masked while reset is held.
   assign bus.gnt            = gnt_oh & {2{rst_n}};
   assign bus.mem_MemWrite   = (state_q == ST_ACCESS) && we_q && !oor_q;
   assign bus.mem_MemRead    = (state_q == ST_ACCESS) && !we_q && !oor_q;
   assign bus.mem_Address    = addr_q;
   assign bus.mem_Write_data = wdata_q;
   assign bus.rsp_valid      = (state_q == ST_RESP) ? sel_q : 2'b00;
   assign bus.rsp_err        = (state_q == ST_RESP) && oor_q;
   assign bus.rsp_rdata      = (state_q == ST_RESP) ? rdata_q : '0;
   assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter against a transaction-level model.
module tb_data_mem_arbiter;

`ifdef DMEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic busy;

   int n_checks;
   int n_fail;
   bit mon_en;
   int pref;

   logic [31:0] env_mem [0:255] = '{default: '0};
   logic [31:0] ref_mem [0:255] = '{default: '0};

   data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Simple memory: async read, write on the rising edge.
   assign bus.mem_Read_data = (bus.mem_Address < 32'd256) ? env_mem[bus.mem_Address[7:0]]
                                                          : 32'hBAD0_BAD0;
   always @(posedge clk) begin
      if (bus.mem_MemWrite && bus.mem_Address < 32'd256) begin
         env_mem[bus.mem_Address[7:0]] <= bus.mem_Write_data;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         check("gnt_onehot", 64'($countones(bus.gnt) <= 1), 64'd1);
         check("rsp_onehot", 64'($countones(bus.rsp_valid) <= 1), 64'd1);
         check("strobe_excl", 64'(bus.mem_MemWrite && bus.mem_MemRead), 64'd0);
      end
   end

   // Model-side winner choice from the arbitration rule.
   function automatic int pick_winner(input logic [1:0] r);
      if (r == 2'b11) return RR_EN ? pref : 0;
      return r[1] ? 1 : 0;
   endfunction

   // Full transaction, called at a negedge with the arbiter idle.
   task automatic txn(input logic [1:0] r, input logic [1:0] we,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
      int          w;
      logic [1:0]  eg;
      logic [31:0] ea, ed, erd;
      logic        ewe, eoor;
      bus.req       = r;
      bus.req_we    = we;
      bus.req_addr  = {a1, a0};
      bus.req_wdata = {d1, d0};
      #1;
      w    = pick_winner(r);
      eg   = 2'b01 << w;
      ea   = (w == 1) ? a1 : a0;
      ed   = (w == 1) ? d1 : d0;
      ewe  = we[w];
      eoor = (ea >= 32'd256);
      if (RR_EN) pref = 1 - w;
      check("busy_idle", busy, 0);
      check("gnt", bus.gnt, eg);
      check("strobe_idle", {bus.mem_MemWrite, bus.mem_MemRead}, 0);
      @(posedge clk);
      #1;
      // Loser keeps requesting; winner's payload is scrambled after the latch.
      bus.req       = r & ~eg;
      bus.req_we    = 2'($urandom);
      bus.req_addr  = {$urandom, $urandom};
      bus.req_wdata = {$urandom, $urandom};
      @(negedge clk);
      check("grant_gnt", bus.gnt, 0);
      check("grant_busy", busy, 1);
      check("grant_strobe", {bus.mem_MemWrite, bus.mem_MemRead}, 0);
      check("grant_addr", bus.mem_Address, ea);
      @(negedge clk);
      check("acc_gnt", bus.gnt, 0);
      check("acc_wr", bus.mem_MemWrite, ewe && !eoor);
      check("acc_rd", bus.mem_MemRead, !ewe && !eoor);
      check("acc_addr", bus.mem_Address, ea);
      if (ewe) check("acc_wdata", bus.mem_Write_data, ed);
      check("acc_rspv", bus.rsp_valid, 0);
      erd = (!ewe && !eoor) ? ref_mem[ea[7:0]] : 32'd0;
      if (ewe && !eoor) ref_mem[ea[7:0]] = ed;
      @(negedge clk);
      check("rsp_valid", bus.rsp_valid, eg);
      check("rsp_err", bus.rsp_err, eoor);
      check("rsp_rdata", bus.rsp_rdata, erd);
      check("rsp_strobe", {bus.mem_MemWrite, bus.mem_MemRead}, 0);
      check("rsp_gnt", bus.gnt, 0);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.req = 2'b00;
      repeat (n) begin
         @(negedge clk);
         check("idle_gnt", bus.gnt, 0);
         check("idle_rspv", bus.rsp_valid, 0);
         check("idle_busy", busy, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r, we;
      logic [31:0] a0, a1;
      n_checks      = 0;
      n_fail        = 0;
      mon_en        = 1'b0;
      pref          = 0;
      rst_n         = 1'b0;
      bus.req       = 2'b11;
      bus.req_we    = 2'b00;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_gnt", bus.gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_rspv", bus.rsp_valid, 0);
      check("rst_strobe", {bus.mem_MemWrite, bus.mem_MemRead}, 0);
      check("rst_addr", bus.mem_Address, 0);
      bus.req = 2'b00;
      rst_n   = 1'b1;
      mon_en  = 1'b1;
      @(negedge clk);

      // Core write then read back.
      txn(2'b01, 2'b01, 32'd5, 32'd0, 32'hDEADBEEF, 32'd0);
      txn(2'b01, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0);

      // DMA out-of-range read.
      txn(2'b10, 2'b00, 32'd0, 32'd256, 32'd0, 32'd0);

      // Tie resolution over four transactions, back to back.
      for (int i = 0; i < 4; i++) begin
         txn(2'b11, 2'b00, 32'd5, 32'd9, 32'd0, 32'd0);
      end

      // Reset during ACCESS of a write: aborted, old data remains.
      txn(2'b01, 2'b01, 32'd7, 32'd0, 32'h1111_2222, 32'd0);
      bus.req       = 2'b01;
      bus.req_we    = 2'b01;
      bus.req_addr  = {32'd0, 32'd7};
      bus.req_wdata = {32'd0, 32'h3333_4444};
      @(negedge clk);
      @(negedge clk);
      check("abort_wr_pre", bus.mem_MemWrite, 1);
      #2 rst_n = 1'b0;
      #1;
      check("abort_strobe", {bus.mem_MemWrite, bus.mem_MemRead}, 0);
      check("abort_busy", busy, 0);
      check("abort_gnt", bus.gnt, 0);
      pref = 0;
      repeat (2) begin
         @(negedge clk);
         check("abort_rspv", bus.rsp_valid, 0);
      end
      bus.req = 2'b00;
      rst_n   = 1'b1;
      @(negedge clk);
      txn(2'b01, 2'b00, 32'd7, 32'd0, 32'd0, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 60; i++) begin
         r  = 2'($urandom_range(1, 3));
         we = 2'($urandom);
         a0 = ($urandom_range(0, 7) == 0) ? 32'(256 + $urandom_range(0, 8)) : 32'($urandom_range(0, 15));
         a1 = ($urandom_range(0, 7) == 0) ? 32'(256 + $urandom_range(0, 8)) : 32'($urandom_range(0, 15));
         txn(r, we, a0, a1, $urandom, $urandom);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
